// File: rtl/debounce_pkg.sv
// ============================================================================
//  debounce_pkg : shared FSM state encoding and defaults for the debouncer
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package debounce_pkg;

  localparam int N_STABLE_DEFAULT = 16;

  // Bit 1 of the encoding is the debounced level of the channel.
  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    WAIT_HI = 2'b01,
    IDLE_HI = 2'b11,
    WAIT_LO = 2'b10
  } db_state_e;

endpackage

`default_nettype wire

// File: rtl/debounce_ch.sv
// ============================================================================
//  debounce_ch : one debounce channel (2-flop synchronizer, FSM, counter)
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module debounce_ch
  import debounce_pkg::*;
#(
  parameter int N_STABLE = N_STABLE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic b,
  output logic e,
  output logic tog
);

  localparam int            CW       = $clog2(N_STABLE + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_STABLE - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  assign sync1_d = b;
  assign sync2_d = sync1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE_LO;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Toggle on the edge that would bring the count to N_STABLE, so the stored
  // count tops out at N_STABLE-1 and never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE_LO: if (sync2_q) begin
        state_d = WAIT_HI;
        cnt_d   = CNT_ONE;
      end
      WAIT_HI: begin
        if (!sync2_q) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HI: if (!sync2_q) begin
        state_d = WAIT_LO;
        cnt_d   = CNT_ONE;
      end
      WAIT_LO: begin
        if (sync2_q) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign e   = state_q[1];
  assign tog = state_d[1] ^ state_q[1];

endmodule

`default_nettype wire

// File: rtl/debounce3.sv
// ============================================================================
//  debounce3 : three independent button debouncers plus a shared change pulse
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module debounce3
  import debounce_pkg::*;
#(
  parameter int N_STABLE = N_STABLE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  output logic e1,
  output logic e2,
  output logic e3,
  output logic chg
);

  logic [2:0] tog;
  logic       chg_q, chg_d;

  debounce_ch #(.N_STABLE(N_STABLE)) u_ch1 (
    .clk(clk), .rst(rst), .b(b1), .e(e1), .tog(tog[0])
  );
  debounce_ch #(.N_STABLE(N_STABLE)) u_ch2 (
    .clk(clk), .rst(rst), .b(b2), .e(e2), .tog(tog[1])
  );
  debounce_ch #(.N_STABLE(N_STABLE)) u_ch3 (
    .clk(clk), .rst(rst), .b(b3), .e(e3), .tog(tog[2])
  );

  // Registered alongside the level flops so the pulse lines up with the new level.
  assign chg_d = |tog;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chg_q <= 1'b0;
    else     chg_q <= chg_d;
  end

  assign chg = chg_q;

endmodule

`default_nettype wire

// File: tb/tb_debounce3.sv
// ============================================================================
//  tb_debounce3 : directed and randomized checks of debounce3 (N_STABLE=4)
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_debounce3;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b1 = 1'b1, b2 = 1'b1, b3 = 1'b1;
  logic e1, e2, e3, chg;

  int checks = 0;
  int errors = 0;

  debounce3 #(.N_STABLE(N)) dut (
    .clk(clk), .rst(rst), .b1(b1), .b2(b2), .b3(b3),
    .e1(e1), .e2(e2), .e3(e3), .chg(chg)
  );

  always #5 clk = ~clk;

  // Reference: the level flips once the last N synchronized samples all differ from it.
  logic [2:0] m_s1, m_s2, m_e;
  logic       m_chg;
  logic [2:0] m_hist [N];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_e = '0; m_chg = 1'b0;
    for (int k = 0; k < N; k++) m_hist[k] = '0;
  endtask

  task automatic model_edge();
    logic [2:0] all_diff;
    for (int k = N - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = m_s2;
    all_diff = 3'b111;
    for (int k = 0; k < N; k++) all_diff &= (m_hist[k] ^ m_e);
    m_e   = m_e ^ all_diff;
    m_chg = |all_diff;
    m_s2  = m_s1;
    m_s1  = {b3, b2, b1};
  endtask

  // Drive at the falling edge, step one rising edge, return at the next falling edge.
  task automatic cycle(input logic [2:0] bv);
    {b3, b2, b1} = bv;
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({e3, e2, e1} !== 3'b000) begin
      errors++; $display("FAIL reset_e: e=%b expected 000", {e3, e2, e1});
    end
    checks++;
    if (chg !== 1'b0) begin
      errors++; $display("FAIL reset_chg: chg=%b expected 0", chg);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({e3, e2, e1, chg} !== 4'b0000) begin
      errors++; $display("FAIL reset_held: e=%b chg=%b expected 000/0", {e3, e2, e1}, chg);
    end
    {b3, b2, b1} = 3'b000;
    rst = 1'b0;
    model_reset();
    for (int t = 0; t < 3; t++) begin
      cycle(3'b000);
      checks++;
      if ({e3, e2, e1, chg} !== 4'b0000) begin
        errors++; $display("FAIL post_reset: e=%b chg=%b expected 000/0", {e3, e2, e1}, chg);
      end
    end
  endtask

  task automatic test_clean_rise();
    logic exp_e1, exp_chg;
    for (int t = 0; t <= 7; t++) begin
      cycle(3'b001);
      exp_e1  = (t >= 5);
      exp_chg = (t == 5);
      checks++;
      if (e1 !== exp_e1 || chg !== exp_chg || e2 !== 1'b0 || e3 !== 1'b0) begin
        errors++;
        $display("FAIL clean_rise edge %0d: e=%b chg=%b expected e=%b chg=%b",
                 t, {e3, e2, e1}, chg, {2'b00, exp_e1}, exp_chg);
      end
    end
    for (int t = 0; t <= 7; t++) begin
      cycle(3'b000);
      exp_e1  = (t < 5);
      exp_chg = (t == 5);
      checks++;
      if (e1 !== exp_e1 || chg !== exp_chg) begin
        errors++;
        $display("FAIL clean_fall edge %0d: e1=%b chg=%b expected e1=%b chg=%b",
                 t, e1, chg, exp_e1, exp_chg);
      end
    end
  endtask

  task automatic test_glitch();
    for (int t = 0; t < 3; t++) cycle(3'b010);
    for (int t = 0; t < 20; t++) begin
      cycle(3'b000);
      checks++;
      if (e2 !== 1'b0 || chg !== 1'b0) begin
        errors++; $display("FAIL glitch cycle %0d: e2=%b chg=%b expected 0/0", t, e2, chg);
      end
    end
  endtask

  task automatic test_simultaneous();
    int pulses;
    logic [2:0] exp_e;
    pulses = 0;
    for (int t = 0; t <= 7; t++) begin
      cycle(3'b101);
      if (chg === 1'b1) pulses++;
      exp_e = (t >= 5) ? 3'b101 : 3'b000;
      checks++;
      if ({e3, e2, e1} !== exp_e || chg !== (t == 5)) begin
        errors++;
        $display("FAIL simultaneous edge %0d: e=%b chg=%b expected e=%b chg=%b",
                 t, {e3, e2, e1}, chg, exp_e, (t == 5));
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL simultaneous_pulses: got %0d expected 1", pulses);
    end
    for (int t = 0; t < 8; t++) cycle(3'b000);
  endtask

  task automatic test_reset_mid_count();
    for (int t = 0; t < 3; t++) cycle(3'b001);
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({e3, e2, e1, chg} !== 4'b0000) begin
      errors++; $display("FAIL mid_reset_async: e=%b chg=%b expected 000/0", {e3, e2, e1}, chg);
    end
    cycle(3'b001);
    rst = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      cycle(3'b001);
      checks++;
      if (e1 !== (t >= 6) || chg !== (t == 6)) begin
        errors++;
        $display("FAIL mid_reset edge %0d after release: e1=%b chg=%b expected e1=%b chg=%b",
                 t, e1, chg, (t >= 6), (t == 6));
      end
    end
    for (int t = 0; t < 8; t++) cycle(3'b000);
  endtask

  task automatic test_bounce();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cycle((i % 2 == 0) ? 3'b100 : 3'b000);
      if (chg === 1'b1) pulses++;
      checks++;
      if (e3 !== 1'b0) begin
        errors++; $display("FAIL bounce cycle %0d: e3=%b expected 0", i, e3);
      end
    end
    for (int t = 1; t <= 8; t++) begin
      cycle(3'b100);
      if (chg === 1'b1) pulses++;
      checks++;
      if (e3 !== (t >= 6)) begin
        errors++; $display("FAIL settle edge %0d: e3=%b expected %b", t, e3, (t >= 6));
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL bounce_pulses: got %0d expected 1", pulses);
    end
    for (int t = 0; t < 8; t++) cycle(3'b000);
  endtask

  task automatic test_random();
    logic [2:0] bv;
    bv = 3'b000;
    for (int c = 0; c < 600; c++) begin
      for (int ch = 0; ch < 3; ch++)
        if ($urandom_range(0, 5) == 0) bv[ch] = ~bv[ch];
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        model_reset();
        cycle(bv);
        rst = 1'b0;
      end
      cycle(bv);
      checks++;
      if ({e3, e2, e1} !== m_e || chg !== m_chg) begin
        errors++;
        $display("FAIL random cycle %0d: e=%b chg=%b expected e=%b chg=%b",
                 c, {e3, e2, e1}, chg, m_e, m_chg);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_rise();
    test_glitch();
    test_simultaneous();
    test_reset_mid_count();
    test_bounce();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
